// File: rtl/rat_intr_pkg.sv
// Shared types and constants for the RAT MCU interrupt controller.
// Imported by the controller top and its bench.
package rat_intr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ISR  = 2'd2
  } intr_state_t;

  localparam int             PC_WIDTH_DEFAULT   = 10;
  localparam logic [9:0]     ISR_VECTOR_DEFAULT = 10'h3FF;
  localparam int             SYNC_STAGES_MIN    = 2;

endpackage

// File: rtl/rat_intr_if.sv
// Signals between the interrupt controller and the control unit.
// INTR is an external async line; it is carried here so the controller has one bus port.
interface rat_intr_if #(
  parameter int PC_WIDTH = 10
);

  logic                INTR;
  logic                SEI;
  logic                CLI;
  logic                INT_ACK;
  logic                RETIE;
  logic                RETID;
  logic                INT_REQ;
  logic                FLG_SHAD_LD;
  logic                FLG_RESTORE;
  logic                I_FLAG;
  logic                IN_ISR;
  logic [PC_WIDTH-1:0] VECTOR_ADDR;

  modport master (
    output INTR, SEI, CLI, INT_ACK, RETIE, RETID,
    input  INT_REQ, FLG_SHAD_LD, FLG_RESTORE, I_FLAG, IN_ISR, VECTOR_ADDR
  );

  modport slave (
    input  INTR, SEI, CLI, INT_ACK, RETIE, RETID,
    output INT_REQ, FLG_SHAD_LD, FLG_RESTORE, I_FLAG, IN_ISR, VECTOR_ADDR
  );

endinterface

// File: rtl/rat_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level input plus rising-edge detector.
// edge_o is a one-cycle pulse, combinational from the last two synchronized samples.
module rat_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic edge_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign edge_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/rat_intr_ctrl.sv
// RAT MCU interrupt controller: latches synchronized INTR edges, gates them with I_FLAG,
// handshakes with the control unit and strobes the Z/C shadow save/restore.
//
// state | meaning
// IDLE  | no request outstanding
// REQ   | INT_REQ asserted, waiting for INT_ACK
// ISR   | executing the service routine, waiting for RETIE/RETID
module rat_intr_ctrl
  import rat_intr_pkg::*;
#(
  parameter int                  SYNC_STAGES = 2,
  parameter int                  PC_WIDTH    = PC_WIDTH_DEFAULT,
  parameter logic [PC_WIDTH-1:0] ISR_VECTOR  = ISR_VECTOR_DEFAULT
) (
  input  logic       clk,
  input  logic       RST_N,
  rat_intr_if.slave  bus
);

  intr_state_t state_q;
  logic        pend_q;
  logic        i_flag_q;
  logic        int_req_q;
  logic        in_isr_q;
  logic        intr_edge;
  logic        ack_ok;
  logic        ret_ok;

  rat_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk_i   (clk),
    .rst_ni  (RST_N),
    .async_i (bus.INTR),
    .edge_o  (intr_edge)
  );

  assign ack_ok = (state_q == REQ) & bus.INT_ACK;
  assign ret_ok = (state_q == ISR) & (bus.RETIE | bus.RETID);

  always_ff @(posedge clk) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      pend_q    <= 1'b0;
      i_flag_q  <= 1'b0;
      int_req_q <= 1'b0;
      in_isr_q  <= 1'b0;
    end else begin
      // A new edge in the ack cycle is a fresh event, so set beats clear.
      if (intr_edge) begin
        pend_q <= 1'b1;
      end else if (ack_ok) begin
        pend_q <= 1'b0;
      end

      if (ack_ok) begin
        i_flag_q <= 1'b0;
      end else if (ret_ok) begin
        i_flag_q <= bus.RETIE;
      end else if (bus.CLI) begin
        i_flag_q <= 1'b0;
      end else if (bus.SEI) begin
        i_flag_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (pend_q && i_flag_q) begin
            state_q   <= REQ;
            int_req_q <= 1'b1;
          end
        end
        REQ: begin
          if (bus.INT_ACK) begin
            state_q   <= ISR;
            int_req_q <= 1'b0;
            in_isr_q  <= 1'b1;
          end else if (!i_flag_q) begin
            state_q   <= IDLE;
            int_req_q <= 1'b0;
          end
        end
        ISR: begin
          if (bus.RETIE || bus.RETID) begin
            state_q  <= IDLE;
            in_isr_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          int_req_q <= 1'b0;
          in_isr_q  <= 1'b0;
        end
      endcase
    end
  end

  // Strobes are combinational so the shadow registers act on the same edge as the control unit.
  assign bus.FLG_SHAD_LD = ack_ok;
  assign bus.FLG_RESTORE = ret_ok;
  assign bus.INT_REQ     = int_req_q;
  assign bus.IN_ISR      = in_isr_q;
  assign bus.I_FLAG      = i_flag_q;
  assign bus.VECTOR_ADDR = ISR_VECTOR;

endmodule
